// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the data-RAM arbiter: FSM states, index width
// and the round-robin one-hot pick used by rr_picker.
package ram_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_NREQ = 8;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First asserted request scanning upward from ptr, wrapping at n.
    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input int unsigned         n,
        input int unsigned         ptr
    );
        logic [MAX_NREQ-1:0] onehot;
        logic                found;
        int unsigned         idx;
        onehot = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx]) begin
                    onehot[idx] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/ram_arbiter_picker.sv
// Combinational rotate-priority encoder: one-hot grant and its index,
// scanning requests from a round-robin pointer.
module rr_picker
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt_c,
    output logic [IDXW-1:0] o_idx_c,
    output logic            o_any_c
);

    always_comb begin
        o_gnt_c = NREQ'(rr_pick(MAX_NREQ'(i_req), NREQ, 32'(i_ptr)));
    end

    always_comb begin
        o_idx_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (o_gnt_c[i]) begin
                o_idx_c = IDXW'(i);
            end
        end
    end

    assign o_any_c = |o_gnt_c;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one async-read data RAM between NREQ requesters,
// with bounded locked bursts. Define RAM_ARB_STATS_EN to add the stat_stall counter.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NREQ      = 2,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ-1:0]       we,
    input  logic [NREQ*WIDTH-1:0] addr,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic [WIDTH-1:0]      ram_address,
    output logic [WIDTH-1:0]      ram_wdata,
    output logic                  ram_enw,
`ifdef RAM_ARB_STATS_EN
    output logic [31:0]           stat_stall,
`endif
    input  logic [WIDTH-1:0]      ram_rdata
);

    localparam int unsigned IDXW = idx_w(NREQ);
    localparam int unsigned CNTW = $clog2(MAX_BURST + 1);

    arb_state_t      r_state, w_state_nxt;
    logic [IDXW-1:0] r_owner, w_owner_nxt;
    logic [IDXW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [CNTW-1:0] r_burst_cnt, w_burst_cnt_nxt;
    logic [NREQ-1:0] r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_rdata;

    logic [NREQ-1:0]  w_owner_oh;
    logic [NREQ-1:0]  w_req_elig;
    logic [NREQ-1:0]  w_gnt;
    logic [IDXW-1:0]  w_idx;
    logic             w_any;
    logic [IDXW-1:0]  w_ptr_after;
    logic [IDXW-1:0]  w_ptr_release;
    logic [CNTW-1:0]  w_burst_inc;
    logic [NREQ-1:0]  w_rd_oh;
    logic [WIDTH-1:0] w_addr_sel;
    logic [WIDTH-1:0] w_wdata_sel;
    logic             w_enw;

    // While locked only the owner may compete; reset blocks every grant.
    assign w_owner_oh = NREQ'(1) << r_owner;
    assign w_req_elig = rst ? '0 : ((r_state == LOCKED) ? (req & w_owner_oh) : req);

    rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .i_req   (w_req_elig),
        .i_ptr   (r_rr_ptr),
        .o_gnt_c (w_gnt),
        .o_idx_c (w_idx),
        .o_any_c (w_any)
    );

    // One-hot AND-OR mux; all zero when nothing is granted.
    always_comb begin
        w_addr_sel  = '0;
        w_wdata_sel = '0;
        w_enw       = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_gnt[i]) begin
                w_addr_sel  = w_addr_sel  | addr[i*WIDTH +: WIDTH];
                w_wdata_sel = w_wdata_sel | wdata[i*WIDTH +: WIDTH];
                w_enw       = w_enw | we[i];
            end
        end
    end

    assign gnt         = w_gnt;
    assign ram_address = w_addr_sel;
    assign ram_wdata   = w_wdata_sel;
    assign ram_enw     = w_enw;
    assign rsp_valid   = rst ? '0 : r_rsp_valid;
    assign rsp_rdata   = rst ? '0 : r_rsp_rdata;

    assign w_rd_oh       = w_gnt & ~we;
    assign w_ptr_after   = (w_idx == IDXW'(NREQ - 1)) ? '0 : w_idx + IDXW'(1);
    assign w_ptr_release = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + IDXW'(1);
    assign w_burst_inc   = r_burst_cnt + CNTW'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_rr_ptr_nxt = w_ptr_after;
                    if (lock[w_idx] && (MAX_BURST > 1)) begin
                        w_state_nxt     = LOCKED;
                        w_owner_nxt     = w_idx;
                        w_burst_cnt_nxt = CNTW'(1);
                    end
                end
            end
            LOCKED: begin
                // Release on owner idle cycle, final beat, or burst limit.
                if (!w_any || !lock[r_owner] || (w_burst_inc == CNTW'(MAX_BURST))) begin
                    w_state_nxt     = IDLE;
                    w_rr_ptr_nxt    = w_ptr_release;
                    w_burst_cnt_nxt = '0;
                end else begin
                    w_burst_cnt_nxt = w_burst_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_rsp_valid <= w_rd_oh;
            if (|w_rd_oh) begin
                r_rsp_rdata <= ram_rdata;
            end
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [31:0] r_stat_stall;

    // Saturating count of cycles where some requester waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_stall <= '0;
        end else if ((|(req & ~w_gnt)) && (r_stat_stall != 32'hFFFF_FFFF)) begin
            r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port synchronous-write, async-read data RAM between NREQ requesters, e.g. CPU load/store unit, JPEG DCT/quantiser write-back and UART loader.
- Grants one requester per cycle, round-robin, and drives the RAM address/wdata/enw.
- Returns registered read data to the winner one cycle later.
- Supports a bounded locked burst so a requester can own the RAM for a multi-word transfer.

Parameters:
- WIDTH, 32, data and address width; matches the RAM.
- NREQ, 2, number of requesters (2..8).
- MAX_BURST, 16, maximum consecutive grants in one lock before forced release.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; held high until granted.
- lock  input  NREQ  with req: keep ownership after this grant.
- we  input  NREQ  1 = write, 0 = read.
- addr  input  NREQ*WIDTH  packed byte-independent word addresses, requester i at [i*WIDTH +: WIDTH].
- wdata  input  NREQ*WIDTH  packed write data.
- gnt  output  NREQ  one-hot grant, combinational, same cycle as RAM access.
- rsp_valid  output  NREQ  one-hot, pulses 1 cycle after a granted read.
- rsp_rdata  output  WIDTH  registered read data, valid with rsp_valid.
- ram_address  output  WIDTH  to RAM address.
- ram_wdata  output  WIDTH  to RAM wdata.
- ram_enw  output  1  to RAM enw.
- ram_rdata  input  WIDTH  from RAM rdata (combinational read).

Behaviour:
- Reset values while rst is high:
  - gnt, rsp_valid, ram_enw = 0; rsp_rdata = 0; ram_address/ram_wdata = 0.
  - state IDLE; rr_ptr = 0; burst_cnt = 0.
- Reset mid-burst or with a read pending drops the lock and the pending rsp_valid. Requesters must re-request.
- A transfer completes in the cycle req[i] & gnt[i]:
  - RAM mux selects requester i; ram_enw = we[i].
  - A read captures ram_rdata into rsp_rdata and sets rsp_valid[i] the next cycle. Latency is exactly 1.
  - A write produces no response.
- No grant when no req is set: ram_enw = 0, address/wdata = 0.
- Arbitration in IDLE:
  - Scan starts at index rr_ptr and wraps modulo NREQ. The first asserted req wins.
  - After a grant to i, rr_ptr = (i+1) mod NREQ, with wrap at NREQ-1 to 0.
  - With simultaneous requests, exactly one gnt; the others stall, holding req and signals stable.
- State machine, states IDLE and LOCKED(owner):
  - IDLE -> LOCKED: grant to i with lock[i] = 1. owner = i, burst_cnt = 1.
  - In LOCKED only owner can be granted; other reqs stall regardless of rr_ptr. Each owner grant increments burst_cnt.
  - LOCKED -> IDLE on any of:
    - an owner grant with lock = 0 (final beat);
    - owner req low for a cycle (no grant that cycle);
    - a grant that makes burst_cnt == MAX_BURST (forced release).
  - On exit: rr_ptr = owner+1 mod NREQ, burst_cnt = 0.
  - Lock asserted after a forced release starts a new lock only via normal round-robin.
- rsp_rdata holds its value when no read completes; rsp_valid is a single-cycle pulse.
- Back-to-back reads by the same requester give consecutive rsp_valid pulses.

Optional Feature:
- RAM_ARB_STATS_EN defined:
  - Adds output stat_stall [31:0], cleared by rst.
  - Increments every cycle in which at least one req is high without gnt; saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package ram_arb_pkg:
  - enum arb_state_t {IDLE, LOCKED};
  - localparam IDXW = $clog2(NREQ) helper function;
  - function rr_pick(req, ptr) returning a one-hot.
- One sub-module, rr_picker: combinational rotate-priority-encode of req from ptr, returning a one-hot grant and the index.
- State, pointer, burst counter and response registers stay in ram_arbiter.

Test Plan:
- Single read: after reset, req[0]=1, we=0, addr=0x10 with RAM[0x10]=0xDEADBEEF -> gnt[0] same cycle; next cycle rsp_valid[0]=1, rsp_rdata=0xDEADBEEF.
- Contention: req=2'b11 held for 4 cycles after reset -> gnt sequence 01,10,01,10; stalled requester's addr never reaches ram_address.
- Write: req[1]=1, we=1, addr=0x5, wdata=0x1234 -> ram_enw=1 that cycle; no rsp_valid; a later read of 0x5 returns 0x1234.
- Lock: req[0] with lock=1 for 3 beats then lock=0, req[1] high throughout -> 4 consecutive gnt[0], then gnt[1].
- Forced release: MAX_BURST=4, req[0] and lock[0] held high, req[1] high -> gnt[0] x4, then gnt[1].
- Reset mid-burst: rst asserted in LOCKED with a read in flight -> next cycle rsp_valid=0, gnt=0; after release, requester 0 wins first if req=2'b11.
